// File: rtl/fsm_serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and the parity helper.
package fsm_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Parity bit from the XOR-reduction of the data; odd_sel flips even to odd.
    function automatic logic parity_bit(input logic data_xor, input logic odd_sel);
        return data_xor ^ odd_sel;
    endfunction

endpackage

// File: rtl/fsm_serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while running and strobes o_bit_tick
// on the last clock of each serial bit.
module fsm_serial_frame_tx_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bit_tick
);

    localparam int                CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_tick = i_run && (r_cnt == LAST);

    // NOTE: async reset goes in the sensitivity list; state updates use <= so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_run || o_bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_serial_frame_tx.sv
// Serial frame transmitter: accepts a word over valid/ready and sends
// start bit, data LSB-first, optional parity and stop bit on a registered tx line.
module fsm_serial_frame_tx
    import fsm_serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_num
);

    localparam int                 BCNT_W   = $clog2(DATA_W) + 1;
    localparam logic [BCNT_W-1:0]  LAST_BIT = BCNT_W'(DATA_W);

    state_e              r_state, w_state_next;
    logic                r_tx, w_tx_next;
    logic                r_done, w_done_next;
    logic                r_parity, w_parity_next;
    logic [DATA_W-1:0]   r_shift, w_shift_next;
    logic [BCNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic                w_bit_tick;

    fsm_serial_frame_tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_run      (r_state != ST_IDLE),
        .o_bit_tick (w_bit_tick)
    );

    // NOTE: every signal gets its hold value first so no path through the case
    // statement leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
        w_parity_next  = r_parity;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;

        case (r_state)
            ST_IDLE: begin
                w_tx_next = LINE_IDLE;
                if (valid_in) begin
                    w_state_next   = ST_START;
                    w_tx_next      = START_LEVEL;
                    w_shift_next   = data_in;
                    w_bit_cnt_next = '0;
                    w_parity_next  = parity_bit(^data_in, 1'(PARITY_ODD));
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_state_next   = ST_DATA;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = BCNT_W'(1);
                end
            end
            ST_DATA: begin
                // r_bit_cnt holds how many data bits have already been put on the line.
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = STOP_LEVEL;
                        end
                    end else begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = STOP_LEVEL;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = LINE_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tx      <= LINE_IDLE;
            r_done    <= 1'b0;
            r_parity  <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
            r_parity  <= w_parity_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    assign tx        = r_tx;
    assign done      = r_done;
    assign state_num = r_state;
    assign busy      = (r_state != ST_IDLE);
    assign ready_out = (r_state == ST_IDLE);

endmodule

// File: tb/tb_fsm_serial_frame_tx.sv
// Scoreboard bench for fsm_serial_frame_tx: three parameter sets run side by side,
// each with a driver pushing accepted words and a monitor checking every line cycle.
module tb_fsm_serial_frame_tx;

    localparam int W   = 8;
    localparam int TMO = 200;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n_fin = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // cfg0: defaults; cfg1: odd parity, 4 clocks per bit; cfg2: no parity bit.
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int             BC    = (g == 1) ? 4 : 1;
        localparam int             PE    = (g == 2) ? 0 : 1;
        localparam int             PO    = (g == 1) ? 1 : 0;
        localparam logic [W-1:0]   FIRST = (g == 0) ? 8'hA5 : ((g == 1) ? 8'h07 : 8'hFF);
        localparam int             FLEN  = (W + PE + 2) * BC;

        logic           rst;
        logic           valid_in;
        logic           ready_out;
        logic           tx;
        logic           busy;
        logic           done;
        logic [W-1:0]   data_in;
        logic [2:0]     state_num;
        logic [W-1:0]   exp_q[$];
        int             n_push   = 0;
        int             n_frames = 0;
        int             n_abort  = 0;

        fsm_serial_frame_tx #(
            .DATA_W     (W),
            .BIT_CYCLES (BC),
            .PARITY_EN  (PE),
            .PARITY_ODD (PO)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .data_in   (data_in),
            .valid_in  (valid_in),
            .ready_out (ready_out),
            .tx        (tx),
            .busy      (busy),
            .done      (done),
            .state_num (state_num)
        );

        // Monitor: reference frame is start 0, data LSB-first, optional parity, stop 1,
        // each bit held BC clocks, then one cycle with done=1 back in IDLE.
        initial begin : monitor
            string        tag;
            logic [W-1:0] cur;
            bit           in_frame;
            int           k;
            int           idx;
            logic         e_tx;
            logic [2:0]   e_st;
            tag      = $sformatf("cfg%0d", g);
            in_frame = 1'b0;
            k        = 0;
            cur      = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    if (in_frame) n_abort++;
                    in_frame = 1'b0;
                    check({tag, " rst tx"},        32'(tx),        32'd1);
                    check({tag, " rst ready"},     32'(ready_out), 32'd1);
                    check({tag, " rst busy"},      32'(busy),      32'd0);
                    check({tag, " rst done"},      32'(done),      32'd0);
                    check({tag, " rst state_num"}, 32'(state_num), 32'd0);
                end else if (in_frame || busy) begin
                    if (!in_frame) begin
                        check({tag, " frame expected"}, 32'(exp_q.size() != 0), 32'd1);
                        cur = '0;
                        if (exp_q.size() != 0) cur = exp_q.pop_front();
                        in_frame = 1'b1;
                        k        = 0;
                    end
                    if (k < FLEN) begin
                        idx = k / BC;
                        if (idx == 0) begin
                            e_tx = 1'b0;
                            e_st = 3'd1;
                        end else if (idx <= W) begin
                            e_tx = cur[idx-1];
                            e_st = 3'd2;
                        end else if (PE != 0 && idx == W + 1) begin
                            e_tx = (^cur) ^ 1'(PO);
                            e_st = 3'd3;
                        end else begin
                            e_tx = 1'b1;
                            e_st = 3'd4;
                        end
                        check($sformatf("%s tx word=%02h k=%0d", tag, cur, k),        32'(tx),        32'(e_tx));
                        check($sformatf("%s state_num word=%02h k=%0d", tag, cur, k), 32'(state_num), 32'(e_st));
                        check({tag, " busy in frame"}, 32'(busy), 32'd1);
                        check({tag, " done in frame"}, 32'(done), 32'd0);
                        k++;
                    end else begin
                        check($sformatf("%s done at end word=%02h", tag, cur), 32'(done), 32'd1);
                        check({tag, " ready at end"},     32'(ready_out), 32'd1);
                        check({tag, " state_num at end"}, 32'(state_num), 32'd0);
                        check({tag, " tx at end"},        32'(tx),        32'd1);
                        n_frames++;
                        in_frame = 1'b0;
                    end
                end else begin
                    check({tag, " idle tx"},        32'(tx),        32'd1);
                    check({tag, " idle done"},      32'(done),      32'd0);
                    check({tag, " idle state_num"}, 32'(state_num), 32'd0);
                    check({tag, " idle ready"},     32'(ready_out), 32'd1);
                end
            end
        end

        // Driver: gap 0 keeps valid_in high (back-to-back, data changes mid-frame),
        // gap <0 resets during data bit 3 of that word.
        initial begin : driver
            string        tag;
            logic [W-1:0] words[$];
            int           gaps[$];
            int           n;
            tag = $sformatf("cfg%0d", g);

            rst      = 1'b1;
            valid_in = 1'b1;
            data_in  = FIRST;
            repeat (2) @(negedge clk);
            valid_in = 1'b0;
            rst      = 1'b0;

            words = '{FIRST, 8'h12, 8'h34, 8'hC3, 8'h5A};
            gaps  = '{2, 0, 2, -1, 1};
            for (int i = 0; i < 20; i++) begin
                words.push_back(W'($urandom));
                gaps.push_back(int'($urandom_range(0, 3)));
            end

            for (int i = 0; i < words.size(); i++) begin
                data_in  = words[i];
                valid_in = 1'b1;
                n = 0;
                while (!ready_out && n <= TMO) begin
                    @(negedge clk);
                    n++;
                end
                check({tag, " handshake within budget"}, 32'(n <= TMO), 32'd1);
                if (n > TMO) break;
                exp_q.push_back(words[i]);
                n_push++;
                @(negedge clk);
                if (gaps[i] < 0) begin
                    valid_in = 1'b0;
                    repeat (4 * BC) @(negedge clk);
                    check({tag, " in data before reset"}, 32'(state_num), 32'd2);
                    #2 rst = 1'b1;
                    #1;
                    check({tag, " async rst tx"},        32'(tx),        32'd1);
                    check({tag, " async rst state_num"}, 32'(state_num), 32'd0);
                    check({tag, " async rst busy"},      32'(busy),      32'd0);
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                end else if (gaps[i] > 0) begin
                    valid_in = 1'b0;
                    data_in  = W'($urandom);
                    n = 0;
                    while (!ready_out && n <= TMO) begin
                        @(negedge clk);
                        n++;
                    end
                    repeat (gaps[i] - 1) @(negedge clk);
                end
            end

            valid_in = 1'b0;
            n = 0;
            while (!ready_out && n <= TMO) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            check({tag, " frames completed"}, 32'(n_frames), 32'(n_push - n_abort));
            check({tag, " frames aborted"},   32'(n_abort),  32'd1);
            check({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
            n_fin++;
        end
    end

    initial begin : finisher
        wait (n_fin == 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, drivers finished=%0d of 3", n_fin);
        $fatal(1, "simulation time limit");
    end

endmodule
